// File: rtl/apb_timer_mc.sv
// apb_timer_mc: NUM_CH up-counters with prescaler/step/compare, shared W1C status, level irq.
// Optional APB_TIMER_MC_SNAPSHOT_EN: a CNT_LO read latches the upper count into a per-channel shadow.
module apb_timer_mc #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_CH         = 4,
   parameter int CNT_WIDTH      = 64
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      irq_o
);

   localparam int CW = CNT_WIDTH;
   localparam logic [3:0] NCH = 4'(NUM_CH);

   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] mode_q, mode_d;
   logic [NUM_CH-1:0] ien_q, ien_d;
   logic [NUM_CH-1:0] st_q, st_d;
   logic [NUM_CH-1:0] match;
   logic [11:0]       psc_q [NUM_CH];
   logic [11:0]       psc_d [NUM_CH];
   logic [11:0]       div_q [NUM_CH];
   logic [11:0]       div_d [NUM_CH];
   logic [15:0]       step_q [NUM_CH];
   logic [15:0]       step_d [NUM_CH];
   logic [CW-1:0]     cnt_q [NUM_CH];
   logic [CW-1:0]     cnt_d [NUM_CH];
   logic [CW-1:0]     cmp_q [NUM_CH];
   logic [CW-1:0]     cmp_d [NUM_CH];
   logic [63:0]       cnt64 [NUM_CH];
   logic [63:0]       cmp64 [NUM_CH];

   logic       acc, wr, rd;
   logic       ch_ok, glb_st, glb_info, addr_ok;
   logic [2:0] ch_idx, off;

   assign acc      = PSEL & PENABLE;
   assign wr       = acc & PWRITE;
   assign rd       = acc & ~PWRITE;
   assign ch_idx   = PADDR[7:5];
   assign off      = PADDR[4:2];
   assign ch_ok    = (PADDR[APB_ADDR_WIDTH-1:8] == '0)
                   && ({1'b0, ch_idx} < NCH)
                   && (off <= 3'd5)
                   && (PADDR[1:0] == 2'b00);
   assign glb_st   = (PADDR == APB_ADDR_WIDTH'(256));
   assign glb_info = (PADDR == APB_ADDR_WIDTH'(260));
   assign addr_ok  = ch_ok | glb_st | glb_info;
   assign PSLVERR  = acc & ~addr_ok;
   assign PREADY   = 1'b1;
   assign irq_o    = |(st_q & ien_q);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt64[i] = 64'(cnt_q[i]);
         cmp64[i] = 64'(cmp_q[i]);
      end
   end

`ifdef APB_TIMER_MC_SNAPSHOT_EN
   logic [31:0] shad_q [NUM_CH];

   always_ff @(posedge HCLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (HRESET) begin
            shad_q[i] <= '0;
         end else if (rd && ch_ok && ch_idx == 3'(i) && off == 3'd2) begin
            shad_q[i] <= cnt64[i][63:32];
         end
      end
   end
`endif

   always_comb begin
      logic        w, tick;
      logic [63:0] t64;
      en_d   = en_q;
      mode_d = mode_q;
      ien_d  = ien_q;
      st_d   = st_q;
      psc_d  = psc_q;
      div_d  = div_q;
      step_d = step_q;
      cnt_d  = cnt_q;
      cmp_d  = cmp_q;
      match  = '0;
      w      = 1'b0;
      tick   = 1'b0;
      t64    = '0;
      if (wr && glb_st) st_d = st_q & ~PWDATA[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
         w        = wr && ch_ok && (ch_idx == 3'(i));
         tick     = en_q[i] && (div_q[i] == psc_q[i]);
         match[i] = en_q[i] && (cnt_q[i] >= cmp_q[i]);
         if (en_q[i]) div_d[i] = tick ? 12'd0 : div_q[i] + 12'd1;
         if (tick) cnt_d[i] = cnt_q[i] + CW'(step_q[i]);
         // Match outranks the increment; a set here also outranks the W1C above.
         if (match[i]) begin
            st_d[i] = 1'b1;
            if (mode_q[i]) begin
               cnt_d[i] = '0;
               div_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i];
               en_d[i]  = 1'b0;
            end
         end
         if (w) begin
            unique case (off)
               3'd0: begin
                  en_d[i]   = PWDATA[0];
                  mode_d[i] = PWDATA[1];
                  ien_d[i]  = PWDATA[2];
                  if (PWDATA[0] && !en_q[i]) div_d[i] = '0;
               end
               3'd1: begin
                  psc_d[i]  = PWDATA[11:0];
                  step_d[i] = PWDATA[31:16];
               end
               3'd2: begin
                  t64        = cnt64[i];
                  t64[31:0]  = PWDATA;
                  cnt_d[i]   = t64[CW-1:0];
               end
               3'd3: begin
                  t64        = cnt64[i];
                  t64[63:32] = PWDATA;
                  cnt_d[i]   = t64[CW-1:0];
               end
               3'd4: begin
                  t64        = cmp64[i];
                  t64[31:0]  = PWDATA;
                  cmp_d[i]   = t64[CW-1:0];
               end
               3'd5: begin
                  t64        = cmp64[i];
                  t64[63:32] = PWDATA;
                  cmp_d[i]   = t64[CW-1:0];
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      PRDATA = '0;
      if (rd && glb_st) begin
         PRDATA = 32'(st_q);
      end else if (rd && glb_info) begin
         PRDATA = {16'(CW), 8'd0, 8'(NUM_CH)};
      end else if (rd && ch_ok) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 3'(i)) begin
               unique case (off)
                  3'd0: PRDATA = {29'd0, ien_q[i], mode_q[i], en_q[i]};
                  3'd1: PRDATA = {step_q[i], 4'd0, psc_q[i]};
                  3'd2: PRDATA = cnt64[i][31:0];
`ifdef APB_TIMER_MC_SNAPSHOT_EN
                  3'd3: PRDATA = shad_q[i];
`else
                  3'd3: PRDATA = cnt64[i][63:32];
`endif
                  3'd4: PRDATA = cmp64[i][31:0];
                  3'd5: PRDATA = cmp64[i][63:32];
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         en_q   <= '0;
         mode_q <= '0;
         ien_q  <= '0;
         st_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            psc_q[i]  <= '0;
            div_q[i]  <= '0;
            step_q[i] <= '0;
            cnt_q[i]  <= '0;
            cmp_q[i]  <= '1;
         end
      end else begin
         en_q   <= en_d;
         mode_q <= mode_d;
         ien_q  <= ien_d;
         st_q   <= st_d;
         for (int i = 0; i < NUM_CH; i++) begin
            psc_q[i]  <= psc_d[i];
            div_q[i]  <= div_d[i];
            step_q[i] <= step_d[i];
            cnt_q[i]  <= cnt_d[i];
            cmp_q[i]  <= cmp_d[i];
         end
      end
   end

endmodule

// File: tb/tb_apb_timer_mc.sv
// tb_apb_timer_mc: scoreboarded APB bench with an arithmetic timing model of the channels.
// Build with APB_TIMER_MC_SNAPSHOT_EN to expect shadowed CNT_HI reads.
module tb_apb_timer_mc;

   localparam int NCH = 4;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic        PWRITE = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR, irq_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      string       nm;
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t sbq[$];
   exp_t mx;

   int p[NCH], s[NCH], c[NCH], t0s[NCH], lat[NCH];
   logic [NCH-1:0] iem;

   apb_timer_mc dut (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq_o)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(negedge HCLK) begin
      if (PSEL && PENABLE) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty got=%0h exp=none", PRDATA);
         end else begin
            mx = sbq.pop_front();
            chk({mx.nm, "_data"}, PRDATA, mx.d);
            chk({mx.nm, "_err"}, PSLVERR, mx.e);
            chk({mx.nm, "_ready"}, PREADY, 1'b1);
         end
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) step();
   endtask

   function automatic logic [11:0] A(input int ch, input int o);
      return 12'(ch * 32 + o);
   endfunction

   task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic e = 1'b0);
      sbq.push_back('{nm: "wr", d: 32'h0, e: e});
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      step();
      PENABLE = 1'b1;
      step();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] d, input string nm,
                     input logic e = 1'b0);
      sbq.push_back('{nm: nm, d: d, e: e});
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      step();
      PENABLE = 1'b1;
      step();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   function automatic logic [31:0] exp_st(input int e);
      logic [31:0] r = '0;
      for (int i = 0; i < NCH; i++) if (e - t0s[i] >= lat[i]) r[i] = 1'b1;
      return r;
   endfunction

   initial begin
      int t0, n, endc, dup;
      logic [63:0] v;
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int t0, n, endc, dup;
      logic [63:0] v;
      @(posedge HCLK);
      #1;
      HRESET = 1'b1;
      repeat (3) step();
      HRESET = 1'b0;

      // reset state
      chk("rst_irq", irq_o, 1'b0);
      chk("rst_pready", PREADY, 1'b1);
      chk("rst_pslverr", PSLVERR, 1'b0);
      chk("rst_prdata", PRDATA, 32'h0);
      for (int ch = 0; ch < NCH; ch++)
         for (int o = 0; o < 6; o++)
            rd(A(ch, o * 4), (o >= 4) ? 32'hFFFF_FFFF : 32'h0, "rst_reg");
      rd(12'h100, 32'h0, "rst_status");
      rd(12'h104, {16'd64, 8'd0, 8'(NCH)}, "info");

      // ch0 one-shot
      wr(A(0, 4), (32'd5 << 16) | 32'd3);
      wr(A(0, 16), 32'h11);
      wr(A(0, 20), 32'h0);
      wr(A(0, 0), 32'h5);
      t0 = cyc;
      n = 0;
      while (!irq_o && n < 100) begin
         step();
         n++;
      end
      chk("oneshot_lat", 64'(cyc - t0), 64'((3 + 1) * ((17 + 4) / 5) + 1));
      rd(12'h100, 32'h1, "os_status");
      rd(A(0, 0), 32'h4, "os_ctrl");
      rd(A(0, 8), 32'h14, "os_cnt_lo");
      rd(A(0, 12), 32'h0, "os_cnt_hi");
      wr(12'h100, 32'h1);
      chk("os_irq_clr", irq_o, 1'b0);
      repeat (4) step();
      rd(12'h100, 32'h0, "os_no_rematch");

      // ch1 periodic, W1C racing a match
      wr(A(1, 4), (32'd1 << 16));
      wr(A(1, 16), 32'd9);
      wr(A(1, 20), 32'h0);
      wr(A(1, 0), 32'h7);
      t0 = cyc;
      wait_to(t0 + 9);
      chk("per_pre", irq_o, 1'b0);
      step();
      chk("per_first", irq_o, 1'b1);
      wr(12'h100, 32'h2);
      chk("per_clr", irq_o, 1'b0);
      wait_to(t0 + 18);
      wr(12'h100, 32'h2);
      chk("w1c_vs_match", irq_o, 1'b1);
      wr(12'h100, 32'h2);
      wait_to(t0 + 29);
      chk("per_gap", irq_o, 1'b0);
      step();
      chk("per_interval", irq_o, 1'b1);
      wr(A(1, 0), 32'h0);
      wr(12'h100, 32'h2);
      chk("per_off", irq_o, 1'b0);

      // ch2 rollover into the upper word
      wr(A(2, 4), (32'd4 << 16) | 32'd1);
      wr(A(2, 16), 32'hFFFF_FFFF);
      wr(A(2, 20), 32'hFFFF_FFFF);
      wr(A(2, 12), 32'h0);
      wr(A(2, 8), 32'hFFFF_FFFE);
      wr(A(2, 0), 32'h1);
      wr(A(2, 0), 32'h0);
      rd(A(2, 8), 32'h2, "roll_lo");
      rd(A(2, 12), 32'h1, "roll_hi");
      wr(A(2, 4), (32'd4 << 16));
      wr(A(2, 12), 32'h0);
      wr(A(2, 8), 32'hFFFF_FFF8);
      wr(A(2, 0), 32'h1);
      t0 = cyc;
      v = 64'hFFFF_FFF8 + 64'(4 * (cyc + 1 - t0));
      rd(A(2, 8), v[31:0], "run_lo");
`ifdef APB_TIMER_MC_SNAPSHOT_EN
      rd(A(2, 12), v[63:32], "snap_hi");
`else
      v = 64'hFFFF_FFF8 + 64'(4 * (cyc + 1 - t0));
      rd(A(2, 12), v[63:32], "live_hi");
`endif
      wr(A(2, 0), 32'h0);

      // all channels, random configs
      for (int i = 0; i < NCH; i++) begin
         do begin
            p[i] = int'($urandom_range(0, 20));
            dup = 0;
            for (int j = 0; j < i; j++) if (p[j] == p[i]) dup = 1;
         end while (dup != 0);
         s[i] = int'($urandom_range(1, 20));
         c[i] = int'($urandom_range(1, 50));
         iem[i] = 1'(i % 2);
         lat[i] = (p[i] + 1) * ((c[i] + s[i] - 1) / s[i]) + 1;
         t0s[i] = 32'h3FFF_FFFF;
      end
      wr(12'h100, 32'hFF);
      for (int i = 0; i < NCH; i++) begin
         wr(A(i, 0), 32'h0);
         wr(A(i, 8), 32'h0);
         wr(A(i, 12), 32'h0);
         wr(A(i, 20), 32'h0);
         wr(A(i, 16), 32'(c[i]));
         wr(A(i, 4), (32'(s[i]) << 16) | 32'(p[i]));
      end
      for (int i = 0; i < NCH; i++) begin
         wr(A(i, 0), {29'd0, iem[i], 2'b01});
         t0s[i] = cyc;
      end
      endc = 0;
      for (int i = 0; i < NCH; i++)
         if (t0s[i] + lat[i] > endc) endc = t0s[i] + lat[i];
      endc += 4;
      fork
         begin
            int g = 0;
            do begin
               rd(12'h100, exp_st(cyc + 1), "rand_status");
               g++;
            end while (exp_st(cyc) != 32'((1 << NCH) - 1) && g < 2000);
         end
         begin
            while (cyc < endc) begin
               step();
               chk("rand_irq", irq_o, |(exp_st(cyc)[NCH-1:0] & iem));
            end
         end
      join
      for (int i = 0; i < NCH; i++) begin
         rd(A(i, 8), 32'(s[i] * ((c[i] + s[i] - 1) / s[i])), "rand_cnt");
         rd(A(i, 0), {29'd0, iem[i], 2'b00}, "rand_ctrl");
      end

      // unmapped and misaligned accesses
      wr(12'h0F0, 32'hFFFF_FFFF, 1'b1);
      wr(12'h102, 32'hFFFF_FFFF, 1'b1);
      wr(12'h018, 32'hFFFF_FFFF, 1'b1);
      rd(12'h0F0, 32'h0, "err_ch7", 1'b1);
      rd(12'h102, 32'h0, "err_misal", 1'b1);
      rd(12'h01C, 32'h0, "err_off", 1'b1);
      rd(12'h200, 32'h0, "err_high", 1'b1);
      rd(12'h100, 32'((1 << NCH) - 1), "err_status_kept");
      rd(A(3, 16), 32'(c[3]), "err_cmp_kept");
      rd(12'h104, {16'd64, 8'd0, 8'(NCH)}, "err_info");

      // reset while counting
      wr(A(3, 0), 32'h3);
      repeat (3) step();
      chk("pre_rst_irq", irq_o, 1'b1);
      HRESET = 1'b1;
      step();
      chk("mid_rst_irq", irq_o, 1'b0);
      HRESET = 1'b0;
      rd(A(3, 8), 32'h0, "rst_cnt");
      rd(A(3, 0), 32'h0, "rst_ctrl");
      rd(A(3, 16), 32'hFFFF_FFFF, "rst_cmp");
      rd(12'h100, 32'h0, "rst_status2");
      repeat (2) step();
      chk("sb_drain", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
